// File: rtl/mult_div_pkg.sv
`default_nettype none
// mult_div_pkg -- shared widths, opcodes and FSM encoding for mult_div_unit. Rev 1.0
package mult_div_pkg;

  localparam int INT_W_DEF  = 15;
  localparam int FRAC_W_DEF = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/restoring_div_core.sv
`default_nettype none
// restoring_div_core -- one quotient bit per step restoring divider. Rev 1.0
module restoring_div_core
  import mult_div_pkg::*;
#(
  parameter int MAG_W = INT_W_DEF + FRAC_W_DEF,
  parameter int DVD_W = INT_W_DEF + 2 * FRAC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [MAG_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient
);

  logic [MAG_W-1:0] rem;
  logic [MAG_W-1:0] dvsr;
  logic [MAG_W:0]   rem_shift;
  logic [MAG_W-1:0] diff;
  logic             ge;

  // Remainder stays below the divisor, so the modulo-2^MAG_W difference is exact when ge.
  assign rem_shift = {rem, quotient[DVD_W-1]};
  assign ge        = rem_shift >= {1'b0, dvsr};
  assign diff      = rem_shift[MAG_W-1:0] - dvsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvsr     <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= '0;
      dvsr     <= divisor;
      quotient <= dividend;
    end else if (step) begin
      rem      <= ge ? diff : rem_shift[MAG_W-1:0];
      quotient <= {quotient[DVD_W-2:0], ge};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit -- iterative sign-magnitude fixed-point multiply/divide. Rev 1.0
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op,
  input  logic [INT_W+FRAC_W:0]   data_a,
  input  logic [INT_W+FRAC_W:0]   data_b,
  output logic [INT_W+FRAC_W:0]   result,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    div_by_zero
);

  localparam int M     = INT_W + FRAC_W;
  localparam int D     = INT_W + 2 * FRAC_W;
  localparam int CNT_W = $clog2(D);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             op_r, sign_a, sign_b, b_zero;
  logic [M-1:0]     mcand;
  logic [2*M-1:0]   prod;
  logic [M:0]       prod_sum;
  logic [D-1:0]     quot;
  logic             accept, last_iter, div_step;
  logic [M-1:0]     fin_mag;
  logic             fin_ovf, fin_dbz, fin_sign;

  assign accept    = start && (state == S_IDLE);
  assign cnt_last  = (op_r == OP_DIV) ? CNT_W'(D - 1) : CNT_W'(M - 1);
  assign last_iter = (cnt == cnt_last);
  assign div_step  = (state == S_RUN) && (op_r == OP_DIV) && !b_zero;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (((op_r == OP_DIV) && b_zero) || last_iter) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift-add: multiplier sits in the low half of prod and is consumed LSB first.
  assign prod_sum = {1'b0, prod[2*M-1:M]} + (prod[0] ? {1'b0, mcand} : {(M+1){1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_MUL;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_r   <= op;
      sign_a <= data_a[M];
      sign_b <= data_b[M];
      b_zero <= ~|data_b[M-1:0];
      mcand  <= data_a[M-1:0];
      prod   <= {{M{1'b0}}, data_b[M-1:0]};
      cnt    <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + CNT_W'(1);
      if (op_r == OP_MUL) prod <= {prod_sum, prod[M-1:1]};
    end
  end

  restoring_div_core #(
    .MAG_W (M),
    .DVD_W (D)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (div_step),
    .dividend ({data_a[M-1:0], {FRAC_W{1'b0}}}),
    .divisor  (data_b[M-1:0]),
    .quotient (quot)
  );

  always_comb begin
    fin_mag = '0;
    fin_ovf = 1'b0;
    fin_dbz = 1'b0;
    if (op_r == OP_DIV) begin
      if (b_zero) begin
        fin_dbz = 1'b1;
        fin_ovf = 1'b1;
        fin_mag = '1;
      end else if (|quot[D-1:M]) begin
        fin_ovf = 1'b1;
        fin_mag = '1;
      end else begin
        fin_mag = quot[M-1:0];
      end
    end else if (|prod[2*M-1:M+FRAC_W]) begin
      fin_ovf = 1'b1;
      fin_mag = '1;
    end else begin
      fin_mag = prod[M+FRAC_W-1:FRAC_W];
    end
    fin_sign = fin_dbz ? sign_a : ((sign_a ^ sign_b) && (|fin_mag));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (state == S_FIN) begin
        result      <= {fin_sign, fin_mag};
        overflow    <= fin_ovf;
        div_by_zero <= fin_dbz;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit -- scoreboard bench with random and directed operations. Rev 1.0
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] data_a, data_b;
  logic [31:0] result;
  logic        busy, done, overflow, div_by_zero;

  mult_div_unit #(.INT_W(15), .FRAC_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .data_a      (data_a),
    .data_b      (data_b),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  int   dones  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference: real-number semantics on magnitudes with 64-bit integer arithmetic.
  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] ma, mb, q;
    ma    = {33'b0, a[30:0]};
    mb    = {33'b0, b[30:0]};
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.acc = 0;
    if (o == 1'b0) begin
      q     = (ma * mb) >> 16;
      e.lat = 32;
    end else if (mb == 64'd0) begin
      q     = 64'd0;
      e.dbz = 1'b1;
      e.ovf = 1'b1;
      e.lat = 2;
    end else begin
      q     = (ma << 16) / mb;
      e.lat = 48;
    end
    if (!e.dbz && q > 64'h7FFF_FFFF) begin
      e.ovf = 1'b1;
      q     = 64'h7FFF_FFFF;
    end
    if (e.dbz) e.res = {a[31], 31'h7FFF_FFFF};
    else       e.res = {(a[31] ^ b[31]) && (q != 64'd0), q[30:0]};
    return e;
  endfunction

  // Caller is positioned just after a negedge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        $display("FAIL busy_timeout: got busy=1 expected idle within 500 cycles");
        $fatal(1);
      end
    end
    e     = model(o, a, b);
    e.acc = cyc + 1;
    sbq.push_back(e);
    start  = 1'b1;
    op     = o;
    data_a = a;
    data_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          me = sbq.pop_front();
          chk("result", 64'(result), 64'(me.res));
          chk("overflow", 64'(overflow), 64'(me.ovf));
          chk("div_by_zero", 64'(div_by_zero), 64'(me.dbz));
          chk("latency", 64'(cyc - me.acc), 64'(me.lat));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom() >> $urandom_range(0, 31);
    w[31] = $urandom_range(0, 1) == 1;
    return w;
  endfunction

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);

    rst_n = 1'b1;
    issue(1'b0, 32'h0002_8000, 32'h8001_8000);
    issue(1'b1, 32'h0007_8000, 32'h0002_0000);
    issue(1'b1, 32'h8001_0000, 32'h0000_0000);
    issue(1'b0, 32'h00C8_0000, 32'h00C8_0000);
    issue(1'b0, 32'h8000_0001, 32'h0000_0001);
    issue(1'b1, 32'h7FFF_0000, 32'h0000_0001);

    issue(1'b0, 32'h0003_0000, 32'h0002_0000);
    repeat (5) @(negedge clk);
    chk("busy_during_run", 64'(busy), 64'd1);
    start  = 1'b1;
    op     = 1'b1;
    data_a = 32'h0001_0000;
    data_b = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = rand_word();
      b = ($urandom_range(0, 9) == 0) ? {rand_word() & 32'h8000_0000} : rand_word();
      issue(1'($urandom_range(0, 1)), a, b);
    end
    drain();

    issue(1'b0, 32'h0002_8000, 32'h0001_0000);
    drain();
    start  = 1'b1;
    op     = 1'b1;
    data_a = 32'h0007_8000;
    data_b = 32'h0002_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    d0 = dones;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_done_after_reset", 64'(dones - d0), 64'd0);
    issue(1'b1, 32'h0007_8000, 32'h0002_0000);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
